// File: rtl/dpram_pkg.sv
// Shared widths and types for the dual-port responder.
// Macro DPRAM_WRITE_BYPASS_EN selects cross-port write-through forwarding on reads.
package dpram_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};
endpackage

// File: rtl/dpram_responder_if.sv
// Core-to-responder bundle: port 0 (stage-1 reads), port 1 (stage-4 write-back), debug status.
interface dpram_responder_if;
  import dpram_pkg::*;

  logic  re_0;
  logic  we_0;
  addr_t addr_0;
  data_t wr_data_0;
  data_t rd_data_0;
  logic  rd_valid_0;

  logic  re_1;
  logic  we_1;
  addr_t addr_1;
  data_t wr_data_1;
  data_t rd_data_1;
  logic  rd_valid_1;

  logic  collision;
  cnt_t  coll_count;

  modport master (
    output re_0, we_0, addr_0, wr_data_0, re_1, we_1, addr_1, wr_data_1,
    input  rd_data_0, rd_valid_0, rd_data_1, rd_valid_1, collision, coll_count
  );

  modport slave (
    input  re_0, we_0, addr_0, wr_data_0, re_1, we_1, addr_1, wr_data_1,
    output rd_data_0, rd_valid_0, rd_data_1, rd_valid_1, collision, coll_count
  );
endinterface

// File: rtl/dpram_read_port.sv
// One registered read port: 1-cycle latency, data held while idle, valid = registered enable.
// DPRAM_WRITE_BYPASS_EN forwards the other port's same-cycle write to this read.
module dpram_read_port
  import dpram_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  re,
  input  addr_t addr,
  input  data_t mem_word,
  input  logic  other_we,
  input  addr_t other_addr,
  input  data_t other_data,
  output data_t rd_data,
  output logic  rd_valid
);

  data_t rd_word;

`ifdef DPRAM_WRITE_BYPASS_EN
  assign rd_word = (other_we && (other_addr == addr)) ? other_data : mem_word;
`else
  // Read-before-write: the other port's write is not visible until the next cycle.
  logic unused_other;
  assign unused_other = &{1'b0, other_we, other_addr, other_data};
  assign rd_word = mem_word;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) rd_data <= rd_word;
    end
  end

endmodule

// File: rtl/dpram_responder.sv
// True dual-port 16x4 array with two registered read ports; port 1 wins same-address write-write.
// Collisions pulse for one cycle and bump a saturating debug counter.
module dpram_responder
  import dpram_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  dpram_responder_if.slave bus
);

  data_t mem [DEPTH];
  logic  same_addr;
  logic  coll_now;
  data_t fwd_to_1;

  assign same_addr = (bus.addr_0 == bus.addr_1);
  assign coll_now  = bus.we_0 & bus.we_1 & same_addr;
  // Port 1 must see the winning write, which is its own when both ports hit the address.
  assign fwd_to_1  = (bus.we_1 && same_addr) ? bus.wr_data_1 : bus.wr_data_0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (bus.we_0) mem[bus.addr_0] <= bus.wr_data_0;
      if (bus.we_1) mem[bus.addr_1] <= bus.wr_data_1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.collision  <= 1'b0;
      bus.coll_count <= '0;
    end else begin
      bus.collision <= coll_now;
      if (coll_now && (bus.coll_count != CNT_MAX))
        bus.coll_count <= bus.coll_count + cnt_t'(1);
    end
  end

  dpram_read_port u_rd_0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .re         (bus.re_0),
    .addr       (bus.addr_0),
    .mem_word   (mem[bus.addr_0]),
    .other_we   (bus.we_1),
    .other_addr (bus.addr_1),
    .other_data (bus.wr_data_1),
    .rd_data    (bus.rd_data_0),
    .rd_valid   (bus.rd_valid_0)
  );

  dpram_read_port u_rd_1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .re         (bus.re_1),
    .addr       (bus.addr_1),
    .mem_word   (mem[bus.addr_1]),
    .other_we   (bus.we_0),
    .other_addr (bus.addr_0),
    .other_data (fwd_to_1),
    .rd_data    (bus.rd_data_1),
    .rd_valid   (bus.rd_valid_1)
  );

endmodule

// File: tb/tb_dpram_responder.sv
// Directed plus randomized bench for dpram_responder against an array-level reference model.
module tb_dpram_responder;
  import dpram_pkg::*;

`ifdef DPRAM_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dpram_responder_if bus ();

  dpram_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] model [16];
  logic [3:0] exp_rd0, exp_rd1;
  logic       exp_v0, exp_v1, exp_coll;
  int         exp_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid_0"}, 8'(bus.rd_valid_0), 8'(exp_v0));
    chk({tag, ".rd_data_0"},  8'(bus.rd_data_0),  8'(exp_rd0));
    chk({tag, ".rd_valid_1"}, 8'(bus.rd_valid_1), 8'(exp_v1));
    chk({tag, ".rd_data_1"},  8'(bus.rd_data_1),  8'(exp_rd1));
    chk({tag, ".collision"},  8'(bus.collision),  8'(exp_coll));
    chk({tag, ".coll_count"}, bus.coll_count,     8'(exp_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    exp_rd0 = 4'h0; exp_rd1 = 4'h0;
    exp_v0 = 1'b0;  exp_v1 = 1'b0;
    exp_coll = 1'b0; exp_cnt = 0;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [3:0] d0,
                       input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] d1);
    bus.re_0 = r0; bus.we_0 = w0; bus.addr_0 = a0; bus.wr_data_0 = d0;
    bus.re_1 = r1; bus.we_1 = w1; bus.addr_1 = a1; bus.wr_data_1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, then check.
  task automatic cycle(input string tag);
    logic [3:0] post [16];
    logic       coll;
    @(posedge clk);
    post = model;
    if (bus.we_0) post[bus.addr_0] = bus.wr_data_0;
    if (bus.we_1) post[bus.addr_1] = bus.wr_data_1;
    coll = bus.we_0 && bus.we_1 && (bus.addr_0 == bus.addr_1);
    exp_v0 = bus.re_0;
    exp_v1 = bus.re_1;
    if (bus.re_0)
      exp_rd0 = (BYP && bus.we_1 && bus.addr_1 == bus.addr_0) ? post[bus.addr_0] : model[bus.addr_0];
    if (bus.re_1)
      exp_rd1 = (BYP && bus.we_0 && bus.addr_0 == bus.addr_1) ? post[bus.addr_1] : model[bus.addr_1];
    exp_coll = coll;
    if (coll && exp_cnt < 255) exp_cnt++;
    model = post;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // 1: read of an untouched address returns zero
    drive(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("t1_read");
    chk("t1_data", 8'(bus.rd_data_0), 8'h00);
    idle();
    cycle("t1_idle");

    // 2: write-back on port 1, then read on port 0
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'hA);
    cycle("t2_write");
    drive(1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("t2_read");
    chk("t2_data", 8'(bus.rd_data_0), 8'h0A);
    idle();
    cycle("t2_single_pulse");

    // 3: same-address write-write, port 1 wins
    drive(1'b0, 1'b1, 4'h9, 4'h2, 1'b0, 1'b1, 4'h9, 4'h7);
    cycle("t3_coll");
    chk("t3_pulse", 8'(bus.collision), 8'h01);
    chk("t3_count", bus.coll_count, 8'h01);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h9, 4'h0);
    cycle("t3_read");
    chk("t3_data", 8'(bus.rd_data_1), 8'h07);

    // 4: cross-port read/write to the same address
    drive(1'b0, 1'b1, 4'hC, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("t4_init");
    drive(1'b1, 1'b0, 4'hC, 4'h0, 1'b0, 1'b1, 4'hC, 4'hE);
    cycle("t4_xport");
    chk("t4_data", 8'(bus.rd_data_0), BYP ? 8'h0E : 8'h01);
    idle();
    cycle("t4_idle");

    // Randomized traffic, addresses biased to a small window to provoke conflicts
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a0, a1;
      a0 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      drive(1'($urandom), 1'($urandom), a0, 4'($urandom),
            1'($urandom), 1'($urandom), a1, 4'($urandom));
      cycle("rand");
    end

    // 5: saturation of the collision counter
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'b1, 4'hB, 4'($urandom), 1'b0, 1'b1, 4'hB, 4'($urandom));
      cycle("t5_sat");
    end
    chk("t5_count_max", bus.coll_count, 8'hFF);
    idle();
    cycle("t5_idle");

    // 6: reset while a read is pending discards it and clears the array
    drive(1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("t6_in_reset");
    idle();
    reset_n = 1'b1;
    cycle("t6_no_pulse");
    chk("t6_valid", 8'(bus.rd_valid_0), 8'h00);
    drive(1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h9, 4'h0);
    cycle("t6_read_5_9");
    drive(1'b1, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'hB, 4'h0);
    cycle("t6_read_c_b");
    idle();
    cycle("t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
